// File: rtl/rfa_wb_drain_arbiter_pkg.sv
// rfa_wb_drain_arbiter_pkg: shared defaults and width helper for the writeback drain arbiter
package rfa_wb_drain_arbiter_pkg;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int DEF_NUM_QUEUES   = 4;
    localparam int DEF_IDX_BITS     = idx_width(DEF_NUM_QUEUES);
    localparam int DEF_STARVE_LIMIT = 3;
    localparam int DEF_CNT_BITS     = 4;
endpackage

// File: rtl/rfa_wb_drain_arbiter_if.sv
// rfa_wb_drain_arbiter_if: writeback queue / LSU request and register-file grant signals
interface rfa_wb_drain_arbiter_if
    import rfa_wb_drain_arbiter_pkg::*;
#(
    parameter int NUM_QUEUES = DEF_NUM_QUEUES,
    parameter int IDX_BITS   = DEF_IDX_BITS
);
    logic [NUM_QUEUES-1:0] in_queue_empty;
    logic                  in_lsu_wr_req;
    logic                  in_rf_stall;
    logic [NUM_QUEUES-1:0] out_queue_entry_serviced;
    logic                  out_alu_sel_valid;
    logic [IDX_BITS-1:0]   out_alu_sel_idx;
    logic                  out_lsu_wr_grant;
    modport master (
        output in_queue_empty, in_lsu_wr_req, in_rf_stall,
        input  out_queue_entry_serviced, out_alu_sel_valid, out_alu_sel_idx, out_lsu_wr_grant
    );
    modport slave (
        input  in_queue_empty, in_lsu_wr_req, in_rf_stall,
        output out_queue_entry_serviced, out_alu_sel_valid, out_alu_sel_idx, out_lsu_wr_grant
    );
endinterface

// File: rtl/rfa_wb_drain_arbiter_rr_priority_pick.sv
// rfa_wb_drain_arbiter_rr_priority_pick: first set request at or after ptr, wrapping modulo N
module rfa_wb_drain_arbiter_rr_priority_pick
    import rfa_wb_drain_arbiter_pkg::*;
#(
    parameter int N = DEF_NUM_QUEUES,
    parameter int W = DEF_IDX_BITS
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    always_comb begin
        int p;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        for (int j = 0; j < N; j++) begin
            p = (int'(ptr) + j) % N;
            if (!found && req[p]) begin
                found  = 1'b1;
                gnt[p] = 1'b1;
                idx    = W'(p);
            end
        end
    end
endmodule

// File: rtl/rfa_wb_drain_arbiter.sv
// rfa_wb_drain_arbiter: grants the register-file write port to the LSU or one ALU writeback queue
// per cycle, round-robin across queues with a starvation cap on back-to-back LSU grants.
module rfa_wb_drain_arbiter
    import rfa_wb_drain_arbiter_pkg::*;
#(
    parameter int NUM_QUEUES   = DEF_NUM_QUEUES,
    parameter int IDX_BITS     = DEF_IDX_BITS,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_BITS     = DEF_CNT_BITS
) (
    input logic clk,
    input logic rst,
    rfa_wb_drain_arbiter_if.slave bus
);
    logic [IDX_BITS-1:0]   rr_ptr;
    logic [CNT_BITS-1:0]   starve_cnt;
    logic [NUM_QUEUES-1:0] pick_gnt;
    logic [IDX_BITS-1:0]   pick_idx;
    logic                  any_alu;
    logic                  force_alu;
    logic                  lsu_gnt;
    logic                  alu_gnt;
    rfa_wb_drain_arbiter_rr_priority_pick #(.N(NUM_QUEUES), .W(IDX_BITS)) u_rr_priority_pick (
        .req (~bus.in_queue_empty),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );
    assign any_alu   = ~&bus.in_queue_empty;
    assign force_alu = any_alu & (starve_cnt >= CNT_BITS'(STARVE_LIMIT));
    // rst gates grants combinationally so an asserted reset drops them in the same cycle
    assign lsu_gnt   = ~rst & ~bus.in_rf_stall & bus.in_lsu_wr_req & ~force_alu;
    assign alu_gnt   = ~rst & ~bus.in_rf_stall & ~lsu_gnt & any_alu;
    assign bus.out_lsu_wr_grant         = lsu_gnt;
    assign bus.out_alu_sel_valid        = alu_gnt;
    assign bus.out_alu_sel_idx          = alu_gnt ? pick_idx : '0;
    assign bus.out_queue_entry_serviced = alu_gnt ? pick_gnt : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            if (alu_gnt)
                rr_ptr <= (pick_idx == IDX_BITS'(NUM_QUEUES - 1)) ? '0 : pick_idx + IDX_BITS'(1);
            starve_cnt <= alu_gnt ? '0 :
                          !lsu_gnt ? starve_cnt :
                          !any_alu ? '0 :
                          &starve_cnt ? starve_cnt : starve_cnt + CNT_BITS'(1);
        end
    end
endmodule

// File: tb/tb_rfa_wb_drain_arbiter.sv
// tb_rfa_wb_drain_arbiter: directed vectors with hand-computed grants for the drain arbiter
module tb_rfa_wb_drain_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    rfa_wb_drain_arbiter_if #(.NUM_QUEUES(4), .IDX_BITS(2)) bus ();
    rfa_wb_drain_arbiter #(.NUM_QUEUES(4), .IDX_BITS(2), .STARVE_LIMIT(3), .CNT_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic check_all(input string tag, input logic [3:0] svc, input logic [1:0] idx,
                             input logic vld, input logic lsu);
        check({tag, ".svc"}, 32'(bus.out_queue_entry_serviced), 32'(svc));
        check({tag, ".idx"}, 32'(bus.out_alu_sel_idx), 32'(idx));
        check({tag, ".vld"}, 32'(bus.out_alu_sel_valid), 32'(vld));
        check({tag, ".lsu"}, 32'(bus.out_lsu_wr_grant), 32'(lsu));
    endtask
    task automatic cyc(input string tag, input logic [3:0] e, input logic l, input logic s,
                       input logic [3:0] svc, input logic [1:0] idx, input logic vld, input logic lsu);
        bus.in_queue_empty = e;
        bus.in_lsu_wr_req  = l;
        bus.in_rf_stall    = s;
        #2;
        check_all(tag, svc, idx, vld, lsu);
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.in_queue_empty = 4'b0000;
        bus.in_lsu_wr_req  = 1'b1;
        bus.in_rf_stall    = 1'b0;
        #3;
        check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post_rst_lsu", 4'b0000, 1, 0, 4'b0000, 2'd0, 0, 1);
        cyc("lsu_idle_q",   4'b1111, 1, 0, 4'b0000, 2'd0, 0, 1);
        cyc("rr0", 4'b0000, 0, 0, 4'b0001, 2'd0, 1, 0);
        cyc("rr1", 4'b0000, 0, 0, 4'b0010, 2'd1, 1, 0);
        cyc("rr2", 4'b0000, 0, 0, 4'b0100, 2'd2, 1, 0);
        cyc("rr3", 4'b0000, 0, 0, 4'b1000, 2'd3, 1, 0);
        cyc("rr4", 4'b0000, 0, 0, 4'b0001, 2'd0, 1, 0);
        cyc("skip_a", 4'b1101, 0, 0, 4'b0010, 2'd1, 1, 0);
        cyc("skip_b", 4'b1110, 0, 0, 4'b0001, 2'd0, 1, 0);
        cyc("skip_c", 4'b0000, 0, 0, 4'b0010, 2'd1, 1, 0);
        cyc("starve0", 4'b1011, 1, 0, 4'b0000, 2'd0, 0, 1);
        cyc("starve1", 4'b1011, 1, 0, 4'b0000, 2'd0, 0, 1);
        cyc("starve2", 4'b1011, 1, 0, 4'b0000, 2'd0, 0, 1);
        cyc("starve3", 4'b1011, 1, 0, 4'b0100, 2'd2, 1, 0);
        cyc("starve4", 4'b1011, 1, 0, 4'b0000, 2'd0, 0, 1);
        cyc("stall_rr0", 4'b0000, 0, 1, 4'b0000, 2'd0, 0, 0);
        cyc("stall_rr1", 4'b0000, 0, 1, 4'b0000, 2'd0, 0, 0);
        cyc("stall_rr2", 4'b0000, 0, 0, 4'b1000, 2'd3, 1, 0);
        cyc("stall_cnt0", 4'b1011, 1, 0, 4'b0000, 2'd0, 0, 1);
        cyc("stall_cnt1", 4'b1011, 1, 0, 4'b0000, 2'd0, 0, 1);
        cyc("stall_cnt2", 4'b1011, 1, 1, 4'b0000, 2'd0, 0, 0);
        cyc("stall_cnt3", 4'b1011, 1, 1, 4'b0000, 2'd0, 0, 0);
        cyc("stall_cnt4", 4'b1011, 1, 0, 4'b0000, 2'd0, 0, 1);
        cyc("stall_cnt5", 4'b1011, 1, 0, 4'b0100, 2'd2, 1, 0);
        cyc("single0", 4'b1110, 0, 0, 4'b0001, 2'd0, 1, 0);
        cyc("single1", 4'b1111, 0, 0, 4'b0000, 2'd0, 0, 0);
        cyc("single2", 4'b1111, 0, 0, 4'b0000, 2'd0, 0, 0);
        bus.in_queue_empty = 4'b0000;
        bus.in_lsu_wr_req  = 1'b0;
        #2;
        check_all("pre_midrst", 4'b0010, 2'd1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check_all("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("after_midrst", 4'b0000, 0, 0, 4'b0001, 2'd0, 1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
